// File: rtl/timer_wb_bridge_if.sv
// Wishbone classic slave-side bus bundle for the timer register front end.
interface timer_wb_bridge_if #(
    parameter int AW = 8
);
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [AW-1:0] wb_adr_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/timer_wb_bridge.sv
// Wishbone classic to timer register-port bridge. Each bus access becomes a
// single-cycle re_o/we_o strobe; partial writes are done as read-merge-write
// because the register file only takes whole 32-bit words.
module timer_wb_bridge #(
    parameter int AW = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    timer_wb_bridge_if.slave  wb,
    output logic              re_o,
    output logic              we_o,
    output logic [AW-1:0]     wb_adr_reg,
    output logic [3:0]        wb_sel_out,
    output logic [31:0]       wb_data_reg_out,
    input  logic [31:0]       wb_data_reg_in
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_MRG  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_ACK  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] dat_lat;     // bus write data held for the merge step
    logic [31:0] rd_dat;      // last completed read, held across writes
    logic [31:0] merged;
    logic        req;
    logic        misaligned;

    assign req        = wb.wb_cyc_i & wb.wb_stb_i;
    assign misaligned = (wb.wb_adr_i[1:0] != 2'b00);

    // Next-state decode; a dropped cyc abandons the transfer without an ack.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (misaligned)                  state_nxt = S_ERR;
                    else if (!wb.wb_we_i)            state_nxt = S_RD;
                    else if (wb.wb_sel_i == 4'hF)    state_nxt = S_WR;
                    else if (wb.wb_sel_i == 4'h0)    state_nxt = S_ACK;
                    else                             state_nxt = S_MRG;
                end
            end
            S_RD:    state_nxt = wb.wb_cyc_i ? S_ACK : S_IDLE;
            S_MRG:   state_nxt = wb.wb_cyc_i ? S_WR  : S_IDLE;
            S_WR:    state_nxt = wb.wb_cyc_i ? S_ACK : S_IDLE;
            S_ACK:   state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte-lane merge: new bus bytes where selected, current register bytes elsewhere.
    always_comb begin
        merged = wb_data_reg_in;
        for (int i = 0; i < 4; i++) begin
            if (wb_sel_out[i]) merged[8*i +: 8] = dat_lat[8*i +: 8];
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Request latch; address and sel stay frozen until the FSM is back in IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wb_adr_reg <= '0;
            wb_sel_out <= '0;
            dat_lat    <= '0;
        end else if (state == S_IDLE && req) begin
            wb_adr_reg <= wb.wb_adr_i;
            wb_sel_out <= wb.wb_sel_i;
            dat_lat    <= wb.wb_dat_i;
        end
    end

    // Register-port write data: direct for full-word writes, merged for partial ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wb_data_reg_out <= '0;
        end else if (state == S_IDLE && req && !misaligned && wb.wb_we_i &&
                     wb.wb_sel_i == 4'hF) begin
            wb_data_reg_out <= wb.wb_dat_i;
        end else if (state == S_MRG && wb.wb_cyc_i) begin
            wb_data_reg_out <= merged;
        end
    end

    // Read data capture; only a read that is not aborted updates the held value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                            rd_dat <= '0;
        else if (state == S_RD && wb.wb_cyc_i) rd_dat <= wb_data_reg_in;
    end

    assign re_o        = (state == S_RD) || (state == S_MRG);
    assign we_o        = (state == S_WR);
    assign wb.wb_ack_o = (state == S_ACK) && wb.wb_cyc_i;
    assign wb.wb_err_o = (state == S_ERR) && wb.wb_cyc_i;
    assign wb.wb_dat_o = rd_dat;

endmodule
